// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, S-box tables, SubBytes FSM state type.
// The inverse S-box table exists only when SUB_BYTES_INV_SBOX_EN is defined.
package aes_pkg;

    localparam int unsigned WORD = 32;
    localparam int unsigned NB   = 128;
    localparam int unsigned BYTE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_bytes_state_t;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef SUB_BYTES_INV_SBOX_EN
    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Input/output handshake bundle for sub_bytes_seq.
//   master: producer/consumer side (drives in_valid, state_in, inv, out_ready)
//   slave : engine side (drives in_ready, out_valid, state_out)
interface sub_bytes_seq_if;
    import aes_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] state_in;
    logic          inv;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] state_out;

    modport master (
        output in_valid, state_in, inv, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, inv, out_ready,
        output in_ready, out_valid, state_out
    );

endinterface

// File: rtl/sbox_byte.sv
// Single-byte combinational S-box lookup.
//   byte_i   : byte to substitute
//   inv_i    : 1 selects the inverse table (only with SUB_BYTES_INV_SBOX_EN)
//   sbox_c_o : substituted byte (combinational)
// Without SUB_BYTES_INV_SBOX_EN only the forward table exists and inv_i is ignored.
module sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    input  logic       inv_i,
    output logic [7:0] sbox_c_o
);

`ifdef SUB_BYTES_INV_SBOX_EN
    assign sbox_c_o = inv_i ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];
`else
    logic unused_inv;
    assign unused_inv = inv_i;
    assign sbox_c_o   = SBOX_FWD[byte_i];
`endif

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: 16 state bytes substituted by LANES S-boxes over
// 16/LANES cycles, low bytes first.
//   clk, rst_n : clock, asynchronous active-low reset
//   io (slave) : in_valid/in_ready/state_in/inv input handshake,
//                out_valid/out_ready/state_out output handshake
// Optional inverse S-box: define SUB_BYTES_INV_SBOX_EN.
module sub_bytes_seq #(
    parameter int unsigned LANES = 4,
    parameter int unsigned NB    = 128
) (
    input logic            clk,
    input logic            rst_n,
    sub_bytes_seq_if.slave io
);

    localparam int unsigned BYTE  = aes_pkg::BYTE;
    localparam int unsigned STEPS = 16 / LANES;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Elaboration-time parameter legality
    if (NB != aes_pkg::NB) begin : g_bad_nb
        $error("sub_bytes_seq: NB must be 128");
    end
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_pkg::sub_bytes_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NB-1:0] work_q, work_d;
    logic [NB-1:0] res_q, res_d;
    logic          mode_q, mode_d;

    logic [3:0]    lane_idx [LANES];
    logic [7:0]    sb_out   [LANES];
    logic          accept_c;

    // Handshake outputs follow the state register; in_ready passes out_ready through in DONE
    assign io.in_ready  = (state_q == aes_pkg::IDLE) ||
                          ((state_q == aes_pkg::DONE) && io.out_ready);
    assign io.out_valid = (state_q == aes_pkg::DONE);
    assign io.state_out = res_q;
    assign accept_c     = io.in_valid && io.in_ready;

    // Lane l handles byte cnt*LANES + l of the work register
    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        assign lane_idx[l] = 4'(cnt_q * LANES + l);

        sbox_byte u_sbox (
            .byte_i   (work_q[BYTE*lane_idx[l] +: BYTE]),
            .inv_i    (mode_q),
            .sbox_c_o (sb_out[l])
        );
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= aes_pkg::IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        res_d   = res_q;
        mode_d  = mode_q;

        unique case (state_q)
            aes_pkg::IDLE: begin
                if (accept_c) begin
                    state_d = aes_pkg::BUSY;
                    work_d  = io.state_in;
                    mode_d  = io.inv;
                    cnt_d   = '0;
                end
            end
            aes_pkg::BUSY: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    res_d[BYTE*lane_idx[l] +: BYTE] = sb_out[l];
                end
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = aes_pkg::DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            aes_pkg::DONE: begin
                if (io.out_ready) begin
                    // Back-to-back: a pending input is latched while the result leaves
                    if (io.in_valid) begin
                        state_d = aes_pkg::BUSY;
                        work_d  = io.state_in;
                        mode_d  = io.inv;
                        cnt_d   = '0;
                    end else begin
                        state_d = aes_pkg::IDLE;
                    end
                end
            end
            default: begin
                state_d = aes_pkg::IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq: one instance per legal LANES value,
// expected results computed from GF(2^8) inversion plus the AES affine map.
module tb_sub_bytes_seq;

    localparam int NDUT = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid  [NDUT];
    logic         inv_in    [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] state_in  [NDUT];
    wire          in_ready_w  [NDUT];
    wire          out_valid_w [NDUT];
    wire  [127:0] state_out_w [NDUT];

    int checks   = 0;
    int failures = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_bytes_seq_if bus ();
        assign bus.in_valid   = in_valid[g];
        assign bus.state_in   = state_in[g];
        assign bus.inv        = inv_in[g];
        assign bus.out_ready  = out_ready[g];
        assign in_ready_w[g]  = bus.in_ready;
        assign out_valid_w[g] = bus.out_valid;
        assign state_out_w[g] = bus.state_out;

        sub_bytes_seq #(.LANES(32'(1) << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .io    (bus)
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        if (a == 8'h00) r = 8'h00;
        else for (int k = 0; k < 254; k++) r = gmul(r, a);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic m);
        logic [127:0] o;
        logic use_inv = m;
`ifndef SUB_BYTES_INV_SBOX_EN
        use_inv = 1'b0;
`endif
        for (int k = 0; k < 16; k++)
            o[8*k +: 8] = use_inv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for out_valid, counting rising edges after the accept edge
    task automatic wait_done(input int i, output int lat);
        lat = 0;
        while (out_valid_w[i] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // One full operation on DUT i with the result handshake taken immediately
    task automatic run_op(input int i, input logic [127:0] d, input logic m,
                          input logic [127:0] exp, input string tag);
        int lat;
        @(negedge clk);
        in_valid[i] = 1'b1; state_in[i] = d; inv_in[i] = m; out_ready[i] = 1'b0;
        chk({tag, " in_ready"}, 128'(in_ready_w[i]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0; inv_in[i] = ~m; state_in[i] = rnd128();
        wait_done(i, lat);
        chk({tag, " latency"}, 128'(lat), 128'(16 >> i));
        chk({tag, " state_out"}, state_out_w[i], exp);
        @(negedge clk); out_ready[i] = 1'b1;
        @(posedge clk); #1;
        chk({tag, " out_valid drop"}, 128'(out_valid_w[i]), 128'd0);
        chk({tag, " state_out held"}, state_out_w[i], exp);
        @(negedge clk); out_ready[i] = 1'b0;
    endtask

    initial begin
        logic [127:0] d1, d2, e1, e2, inv_exp;
        logic         m1, m2;
        int           lat;

        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i] = 1'b0; inv_in[i] = 1'b0; out_ready[i] = 1'b0; state_in[i] = '0;
        end
        for (int v = 0; v < 256; v++) fwd_tab[v] = sbox_math(8'(v));
        for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);

        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("rst L%0d state_out", 1 << i), state_out_w[i], 128'd0);
            chk($sformatf("rst L%0d out_valid", 1 << i), 128'(out_valid_w[i]), 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("post-rst L%0d in_ready", 1 << i), 128'(in_ready_w[i]), 128'd1);

        // Known vectors and random states on every lane configuration
        for (int i = 0; i < NDUT; i++) begin
            run_op(i, 128'd0, 1'b0, {16{8'h63}}, $sformatf("zero L%0d", 1 << i));
            run_op(i, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                   128'h76abd7fe2b670130c56f6bf27b777c63, $sformatf("ramp L%0d", 1 << i));
            for (int r = 0; r < 3; r++) begin
                d1 = rnd128(); m1 = 1'($urandom_range(0, 1));
                run_op(i, d1, m1, model(d1, m1), $sformatf("rand L%0d #%0d", 1 << i, r));
            end
        end

        // Inverse select on 0x63..63
`ifdef SUB_BYTES_INV_SBOX_EN
        inv_exp = 128'd0;
`else
        inv_exp = {16{8'hfb}};
`endif
        run_op(2, {16{8'h63}}, 1'b1, inv_exp, "inv 63");

        // Backpressure then back-to-back acceptance on LANES=4
        d1 = rnd128(); m1 = 1'($urandom_range(0, 1)); e1 = model(d1, m1);
        d2 = rnd128(); m2 = 1'($urandom_range(0, 1)); e2 = model(d2, m2);
        @(negedge clk);
        in_valid[2] = 1'b1; state_in[2] = d1; inv_in[2] = m1; out_ready[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        state_in[2] = d2; inv_in[2] = m2;
        wait_done(2, lat);
        chk("bp first latency", 128'(lat), 128'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp hold %0d state_out", c), state_out_w[2], e1);
            chk($sformatf("bp hold %0d out_valid", c), 128'(out_valid_w[2]), 128'd1);
            chk($sformatf("bp hold %0d in_ready", c), 128'(in_ready_w[2]), 128'd0);
        end
        out_ready[2] = 1'b1;
        #1 chk("b2b in_ready", 128'(in_ready_w[2]), 128'd1);
        @(posedge clk); #1;
        chk("b2b no idle out_valid", 128'(out_valid_w[2]), 128'd0);
        chk("b2b no idle in_ready", 128'(in_ready_w[2]), 128'd0);
        @(negedge clk);
        in_valid[2] = 1'b0; out_ready[2] = 1'b0; inv_in[2] = ~m2;
        wait_done(2, lat);
        chk("b2b latency", 128'(lat), 128'd4);
        chk("b2b state_out", state_out_w[2], e2);
        @(negedge clk); out_ready[2] = 1'b1;
        @(posedge clk); #1;
        chk("b2b out_valid drop", 128'(out_valid_w[2]), 128'd0);
        @(negedge clk); out_ready[2] = 1'b0;

        // Reset during BUSY step 2 abandons the operation
        @(negedge clk);
        in_valid[2] = 1'b1; state_in[2] = rnd128(); inv_in[2] = 1'b0;
        @(posedge clk);
        @(negedge clk); in_valid[2] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid-busy rst out_valid", 128'(out_valid_w[2]), 128'd0);
        chk("mid-busy rst state_out", state_out_w[2], 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("after rst in_ready", 128'(in_ready_w[2]), 128'd1);
        chk("after rst out_valid", 128'(out_valid_w[2]), 128'd0);
        d1 = rnd128(); m1 = 1'($urandom_range(0, 1));
        run_op(2, d1, m1, model(d1, m1), "fresh after rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Sequential, parametrised AES SubBytes engine. Accepts a 128-bit state over a valid/ready handshake and substitutes its 16 bytes using LANES byte S-boxes, time-multiplexed over 16/LANES cycles. Returns the result over a second valid/ready handshake. It replaces the fully parallel 16-S-box substitution in the round datapath where area matters, and optionally provides the inverse S-box for the decrypt path.

## Interface
- `LANES`, default 4: S-box instances working in parallel; legal values 1, 2, 4, 8, 16.
- `NB`, default 128: state width in bits; fixed at 128, any other value is a elaboration error.
- `clk` in, 1: rising-edge clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: `state_in` and `inv` are valid.
- `in_ready` out, 1: block can accept a state this cycle.
- `state_in` in, NB: input state; byte i is `state_in[8i+7:8i]`.
- `inv` in, 1: 1 selects the inverse S-box. Sampled with the input.
- `out_valid` out, 1: `state_out` holds a completed result.
- `out_ready` in, 1: consumer accepts the result.
- `state_out` out, NB: substituted state, same byte mapping as the input.

## Operation
- STEPS = 16/LANES.
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - BUSY: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1, `in_ready`=`out_ready`.
- IDLE → BUSY on `in_valid && in_ready`:
  - latch `state_in` into the work register and `inv` into the mode register;
  - clear the step counter `cnt`.
- BUSY, each cycle:
  - bytes `cnt*LANES` … `cnt*LANES+LANES-1` pass through the S-boxes;
  - the results are written into the same byte positions of the result register;
  - `cnt` increments.
  - Low bytes are processed first.
- BUSY → DONE on the cycle where `cnt == STEPS-1`.
- DONE:
  - the result register drives `state_out`;
  - it is held stable while `out_valid && !out_ready`.
- DONE with `out_ready`=1 and `in_valid`=0 → IDLE.
- DONE with `out_ready`=1 and `in_valid`=1 → BUSY directly. The new state and mode are latched in that same cycle (back-to-back).
- Inputs are ignored whenever `in_ready`=0.
- `cnt` width is clog2(STEPS), minimum 1 bit. With LANES=16 (STEPS=1), BUSY lasts exactly one cycle.
- The latched `inv` is constant for the duration of one operation. Toggling the `inv` input mid-operation has no effect.
- `state_out` is registered and keeps its last value after leaving DONE.

## Timing
- Reset, asynchronous assertion:
  - FSM = IDLE, `cnt`=0;
  - `state_out` = 0, `out_valid` = 0, `in_ready` = 1 (following reset release);
  - mode register = 0.
- Reset mid-BUSY or mid-DONE: the operation is abandoned and the result is lost. No output handshake occurs.
- Latency: handshake accepted at edge k → `out_valid` high after edge k+STEPS.
- Throughput:
  - STEPS+1 cycles per state when the consumer takes the result while a new input is pending;
  - one IDLE cycle more if the producer waits.
- S-box lookups are combinational within the cycle. There is no extra pipeline register.

## Configuration
- `SUB_BYTES_INV_SBOX_EN` defined:
  - the inverse S-box table is compiled in;
  - latched `inv`=1 selects it per operation.
- Not defined:
  - the inverse table is not instantiated;
  - the `inv` port remains present but is ignored;
  - every operation uses the forward S-box.

## Structure
- Shared package `aes_pkg`:
  - `WORD` (32), `NB` (128), `BYTE` (8);
  - the forward S-box constant array;
  - the inverse S-box constant array, guarded by the macro;
  - FSM state typedef `sub_bytes_state_t` (IDLE, BUSY, DONE).
- One sub-module, `sbox_byte`: 8-bit in, `inv` select, 8-bit out, combinational lookup from the package tables. Instantiated LANES times via generate.

## Test plan
- LANES=4, `state_in`=0, `inv`=0 → after 4 cycles `state_out` = 0x6363…63 (all 16 bytes 0x63), `out_valid`=1.
- `state_in`=0x0f0e0d0c0b0a09080706050403020100 → `state_out`=0x76abd7fe2b670130c56f6bf27b777c63. Repeat for LANES=1, 2, 8, 16 with latencies 16, 8, 2, 1.
- Macro defined, `inv`=1, `state_in`=0x6363…63 → `state_out`=0. Macro undefined, same stimulus → `state_out`=0xfbfb…fb (forward S-box of 0x63).
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `state_out` and `out_valid` stable, `in_ready`=0. Then raise `out_ready` with `in_valid`=1 → next state accepted in the same cycle, no IDLE cycle.
- Assert `rst_n`=0 at BUSY step 2 → `out_valid`=0 and `state_out`=0 immediately. After release, `in_ready`=1 and a fresh operation completes correctly.
